// File: rtl/wbc_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wbc_arbiter
//  Purpose  : Round-robin Wishbone classic arbiter. NM masters share one slave
//             bus, and the owner keeps its grant for its whole CYC burst.
//             Optional strobe watchdog enabled by WBC_ARBITER_TIMEOUT_EN.
//  Revision : 1.0  initial release
// ============================================================================
module wbc_arbiter #(
    parameter int NM        = 4,
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NM-1:0]               m_cyc,
    input  logic [NM-1:0]               m_stb,
    input  logic [NM-1:0]               m_we,
    input  logic [NM*ADDRWIDTH-1:0]     m_adr,
    input  logic [NM*DATAWIDTH-1:0]     m_dat_w,
    input  logic [NM*(DATAWIDTH/8)-1:0] m_sel,
    output logic [NM-1:0]               m_ack,
    output logic [NM-1:0]               m_err,
    output logic [DATAWIDTH-1:0]        m_dat_r,
    output logic                        s_cyc,
    output logic                        s_stb,
    output logic                        s_we,
    output logic [ADDRWIDTH-1:0]        s_adr,
    output logic [DATAWIDTH-1:0]        s_dat_w,
    output logic [DATAWIDTH/8-1:0]      s_sel,
    input  logic                        s_ack,
    input  logic                        s_err,
    input  logic [DATAWIDTH-1:0]        s_dat_r,
    output logic [NM-1:0]               grant
);

    localparam int SW = DATAWIDTH / 8;
    localparam int IW = (NM > 1) ? $clog2(NM) : 1;

    if (NM < 2 || NM > 8 || (DATAWIDTH % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
        $error("wbc_arbiter: unsupported parameter set");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t          state_q;
    logic [NM-1:0]   grant_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   ptr_q;

    logic            w_busy;
    logic            w_timeout;
    logic            w_win_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic [NM-1:0]   w_win_oh;
    logic [IW-1:0]   w_next_ptr;

    assign w_busy     = (state_q == ST_BUSY);
    assign w_next_ptr = (owner_q == IW'(NM - 1)) ? '0 : owner_q + IW'(1);
    assign grant      = grant_q;
    assign m_dat_r    = s_dat_r;

    // Rotating priority search: first requester at or above the pointer wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win       = '0;
        w_idx       = '0;
        w_win_oh    = '0;
        for (int k = 0; k < NM; k++) begin
            w_idx = IW'((int'(ptr_q) + k) % NM);
            if (!w_win_found && m_cyc[w_idx]) begin
                w_win_found = 1'b1;
                w_win       = w_idx;
            end
        end
        w_win_oh[w_win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_win_found) begin
                        state_q <= ST_BUSY;
                        grant_q <= w_win_oh;
                        owner_q <= w_win;
                    end
                end
                ST_BUSY: begin
                    // Releasing always passes through IDLE, giving one dead cycle.
                    if (!m_cyc[owner_q] || w_timeout) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        ptr_q   <= w_next_ptr;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc   = w_busy & m_cyc[owner_q] & ~w_timeout;
        s_stb   = w_busy & m_cyc[owner_q] & m_stb[owner_q] & ~w_timeout;
        s_we    = w_busy & m_we[owner_q];
        s_adr   = w_busy ? m_adr[owner_q*ADDRWIDTH +: ADDRWIDTH] : '0;
        s_dat_w = w_busy ? m_dat_w[owner_q*DATAWIDTH +: DATAWIDTH] : '0;
        s_sel   = w_busy ? m_sel[owner_q*SW +: SW] : '0;
        m_ack   = '0;
        m_err   = '0;
        if (w_busy) begin
            m_ack[owner_q] = s_ack & s_stb;
            m_err[owner_q] = (s_err & s_stb) | w_timeout;
        end
    end

`ifdef WBC_ARBITER_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? 16 : 8;

    logic [CW-1:0] tmo_q;

    assign w_timeout = w_busy && (tmo_q == CW'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst || !w_busy || !s_stb || s_ack || s_err) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + CW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wbc_arbiter.sv
`default_nettype none
// Testbench for wbc_arbiter: directed scenarios followed by random traffic,
// every cycle compared against an owner/pointer reference model.
module tb_wbc_arbiter;
    localparam int NM  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic [NM-1:0]      m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_dat_w;
    logic [NM*SW-1:0]   m_sel;
    logic [NM-1:0]      m_ack, m_err, grant;
    logic [DW-1:0]      m_dat_r, s_dat_w, s_dat_r;
    logic               s_cyc, s_stb, s_we, s_ack, s_err;
    logic [AW-1:0]      s_adr;
    logic [SW-1:0]      s_sel;

    wbc_arbiter #(.NM(NM), .ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_ack(m_ack), .m_err(m_err),
        .m_dat_r(m_dat_r), .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack),
        .s_err(s_err), .s_dat_r(s_dat_r), .grant(grant)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 when idle), rotation pointer, stall count.
    int mo_owner = -1;
    int mo_ptr   = 0;
    int mo_cnt   = 0;
    logic [NM-1:0] exp_ack_v = '0;
    logic [NM-1:0] exp_err_v = '0;
    int beats [NM];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_to();
`ifdef WBC_ARBITER_TIMEOUT_EN
        return (mo_owner >= 0) && (mo_cnt == TMO);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_cycle();
        logic [NM-1:0] eg, eack, eerr;
        logic          ecyc, estb, ewe;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic [SW-1:0] esel;
        bit            to;
        int            g;
        to = model_to();
        eg = '0; eack = '0; eerr = '0;
        ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
        eadr = '0; edat = '0; esel = '0;
        if (mo_owner >= 0) begin
            g       = mo_owner;
            eg[g]   = 1'b1;
            ecyc    = m_cyc[g] && !to;
            estb    = m_cyc[g] && m_stb[g] && !to;
            ewe     = m_we[g];
            eadr    = m_adr[g*AW +: AW];
            edat    = m_dat_w[g*DW +: DW];
            esel    = m_sel[g*SW +: SW];
            eack[g] = s_ack && estb;
            eerr[g] = (s_err && estb) || to;
        end
        exp_ack_v = eack;
        exp_err_v = eerr;
        chk("grant",   64'(grant),   64'(eg));
        chk("s_cyc",   64'(s_cyc),   64'(ecyc));
        chk("s_stb",   64'(s_stb),   64'(estb));
        chk("s_we",    64'(s_we),    64'(ewe));
        chk("s_adr",   64'(s_adr),   64'(eadr));
        chk("s_dat_w", 64'(s_dat_w), 64'(edat));
        chk("s_sel",   64'(s_sel),   64'(esel));
        chk("m_ack",   64'(m_ack),   64'(eack));
        chk("m_err",   64'(m_err),   64'(eerr));
        chk("m_dat_r", 64'(m_dat_r), 64'(s_dat_r));
    endtask

    task automatic model_update();
        bit to;
        int o;
        to = model_to();
        if (rst) begin
            mo_owner = -1; mo_ptr = 0; mo_cnt = 0;
        end else if (mo_owner < 0) begin
            mo_cnt = 0;
            for (int k = 0; k < NM; k++) begin
                if (mo_owner < 0 && m_cyc[(mo_ptr + k) % NM]) mo_owner = (mo_ptr + k) % NM;
            end
        end else begin
            o = mo_owner;
            if (!m_cyc[o] || to) begin
                mo_ptr = (o + 1) % NM; mo_owner = -1; mo_cnt = 0;
            end else if (m_stb[o] && !s_ack && !s_err) begin
                mo_cnt++;
            end else begin
                mo_cnt = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_m(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic [SW-1:0] sel);
        m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we;
        m_adr[i*AW +: AW] = adr; m_dat_w[i*DW +: DW] = dat; m_sel[i*SW +: SW] = sel;
    endtask

    task automatic clear_all();
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_w = '0; m_sel = '0;
        s_ack = 1'b0; s_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear_all(); s_dat_r = '0;
        foreach (beats[i]) beats[i] = 0;
        #1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_s_cyc", 64'(s_cyc), 64'h0);

        // Lone read by master 2.
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h2000_0010, '0, 4'hF);
        tick();
        chk("t1_grant", 64'(grant), 64'h4);
        s_ack = 1'b1; s_dat_r = 32'hDEADBEEF; #1;
        chk("t1_ack",   64'(m_ack),   64'h4);
        chk("t1_dat_r", 64'(m_dat_r), 64'hDEADBEEF);
        chk("t1_adr",   64'(s_adr),   64'h2000_0010);
        tick();
        s_ack = 1'b0; set_m(2, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("t1_release", 64'(grant), 64'h0);

        // All four request: rotation 0,1,2,3 with a dead cycle between owners.
        do_reset();
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, 1'b0, AW'(32'h100 * i), '0, 4'hF);
        for (int n = 0; n < NM; n++) begin
            tick();
            chk("t2_grant", 64'(grant), 64'(1 << n));
            s_ack = 1'b1; tick(); s_ack = 1'b0;
            set_m(n, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            tick();
            chk("t2_gap", 64'(grant), 64'h0);
        end

        // Master 1 burst of three beats while master 0 waits.
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h1000, '0, 4'hF);
        tick();
        chk("t3_grant1", 64'(grant), 64'h2);
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0, '0, 4'hF);
        for (int b = 0; b < 3; b++) begin
            s_ack = 1'b1; #1;
            chk("t3_ack", 64'(m_ack), 64'h2);
            tick();
            m_adr[1*AW +: AW] = AW'(32'h1004 + 4 * b);
        end
        s_ack = 1'b0; set_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        chk("t3_gap", 64'(grant), 64'h0);
        tick();
        chk("t3_grant0", 64'(grant), 64'h1);

        // Write from master 0 while granted.
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 4'b0011); #1;
        chk("t6_sel",   64'(s_sel),   64'h3);
        chk("t6_we",    64'(s_we),    64'h1);
        chk("t6_dat_w", 64'(s_dat_w), 64'h1234_5678);
        s_ack = 1'b1; tick(); s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        tick();

        // Reset while master 3 owns the bus mid-strobe.
        set_m(3, 1'b1, 1'b1, 1'b0, 32'h3000, '0, 4'hF);
        tick();
        chk("t4_grant3", 64'(grant), 64'h8);
        do_reset();
        chk("t4_grant", 64'(grant), 64'h0);
        chk("t4_s_cyc", 64'(s_cyc), 64'h0);
        for (int i = 0; i < NM; i++) set_m(i, 1'b1, 1'b1, 1'b0, AW'(i), '0, 4'hF);
        tick();
        chk("t4_ptr0", 64'(grant), 64'h1);
        clear_all(); tick(); tick();

`ifdef WBC_ARBITER_TIMEOUT_EN
        // Stalled slave: watchdog fires TMO cycles after the first strobe.
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h2000, '0, 4'hF);
        tick();
        for (int k = 0; k < TMO; k++) begin
            chk("t5_noerr", 64'(m_err), 64'h0);
            tick();
        end
        chk("t5_err",   64'(m_err), 64'h4);
        chk("t5_s_cyc", 64'(s_cyc), 64'h0);
        clear_all(); tick();
        chk("t5_idle", 64'(grant), 64'h0);
        tick();
`endif

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (m_cyc[i]) begin
                    if (exp_ack_v[i] || exp_err_v[i]) begin
                        beats[i]--;
                        if (beats[i] <= 0) set_m(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
                        else set_m(i, 1'b1, ($urandom % 4) != 0, 1'($urandom),
                                   AW'($urandom), DW'($urandom), SW'($urandom));
                    end else if (!m_stb[i]) begin
                        m_stb[i] = 1'($urandom);
                    end else if (grant[i] == 1'b0 && ($urandom % 32) == 0) begin
                        set_m(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
                    end
                end else if (($urandom % 4) == 0) begin
                    beats[i] = 1 + int'($urandom % 4);
                    set_m(i, 1'b1, ($urandom % 4) != 0, 1'($urandom),
                          AW'($urandom), DW'($urandom), SW'($urandom));
                end
            end
            begin
                int r;
                r = int'($urandom % 10);
                s_ack = (r < 5);
                s_err = (r == 5);
            end
            s_dat_r = DW'($urandom);
            rst = (($urandom % 200) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
